// File: rtl/gng_ctrl.sv
// gng_ctrl - sequencer for the Gaussian noise datapath.
//
// Fetches one 48-bit uniform word per sample from the URNG, splits it into
// sign, segment index (leading-zero count of u[46:32] plus u[31:29]) and the
// polynomial operand u[28:14]. The operands are held on the datapath until
// dp_done, the magnitude is saturated to 15 bits and signed, and the sample is
// pushed into a small output FIFO read through a valid/ready interface.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   enable              keep generating samples while high
//   urng_data/valid     uniform word input; urng_ready accepts it
//   dp_dataa/segment    operands presented to the datapath (held stable)
//   dp_result/done      datapath magnitude and completion strobe
//   noise_data/valid    FIFO head (signed sample) and non-empty flag
//   noise_ready         consumer pops the FIFO head
//   busy                FSM is not idle
//   timeout_err         sticky datapath-timeout flag
//   sample_cnt          wrapping count of samples pushed into the FIFO
module gng_ctrl #(
    parameter int TIMEOUT    = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [47:0] urng_data,
    input  logic        urng_valid,
    output logic        urng_ready,
    output logic [14:0] dp_dataa,
    output logic [6:0]  dp_segment,
    input  logic [15:0] dp_result,
    input  logic        dp_done,
    output logic [15:0] noise_data,
    output logic        noise_valid,
    input  logic        noise_ready,
    output logic        busy,
    output logic        timeout_err,
    output logic [31:0] sample_cnt
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_PUSH   = 3'd4;

    // Leading zeros of the 15-bit exponent field; an all-zero field clamps to 15.
    function automatic logic [3:0] count_lz(input logic [14:0] f);
        logic [3:0] n;
        logic       found;
        n     = 4'd15;
        found = 1'b0;
        for (int i = 14; i >= 0; i--) begin
            if (!found && f[i]) begin
                n     = 4'(14 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    // Clamp the unsigned magnitude to 15 bits so negation never yields -32768.
    function automatic logic signed [15:0] sign_sat(input logic sgn, input logic [15:0] res);
        logic [15:0] mag;
        mag = (res > 16'h7FFF) ? 16'h7FFF : res;
        return sgn ? $signed(~mag + 16'd1) : $signed(mag);
    endfunction

    logic [2:0]  state_q,      state_d;
    logic [7:0]  wait_cnt_q,   wait_cnt_d;
    logic [14:0] dataa_q,      dataa_d;
    logic [6:0]  segment_q,    segment_d;
    logic        sign_q,       sign_d;
    logic [15:0] result_q,     result_d;
    logic        timeout_q,    timeout_d;
    logic [31:0] sample_cnt_q, sample_cnt_d;
    logic [AW:0] wr_ptr_q,     wr_ptr_d;
    logic [AW:0] rd_ptr_q,     rd_ptr_d;
    logic [15:0] mem_q [FIFO_DEPTH];
    logic [15:0] mem_d [FIFO_DEPTH];

    logic [AW:0]        fifo_count;
    logic               fifo_full;
    logic               pop;
    logic signed [15:0] push_sample;
    logic               unused_bits;

    assign unused_bits = ^urng_data[13:0];

    assign fifo_count  = wr_ptr_q - rd_ptr_q;
    assign fifo_full   = (fifo_count == (AW + 1)'(FIFO_DEPTH));
    assign noise_valid = (wr_ptr_q != rd_ptr_q);
    assign pop         = noise_valid && noise_ready;
    assign push_sample = sign_sat(sign_q, result_q);

    assign noise_data  = mem_q[rd_ptr_q[AW-1:0]];
    assign urng_ready  = (state_q == S_FETCH);
    assign busy        = (state_q != S_IDLE);
    assign dp_dataa    = dataa_q;
    assign dp_segment  = segment_q;
    assign timeout_err = timeout_q;
    assign sample_cnt  = sample_cnt_q;

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        dataa_d      = dataa_q;
        segment_d    = segment_q;
        sign_d       = sign_q;
        result_d     = result_q;
        timeout_d    = timeout_q;
        sample_cnt_d = sample_cnt_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        mem_d        = mem_q;

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (enable && !fifo_full) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // A word offered in the same cycle enable drops is still taken.
                if (urng_valid) begin
                    sign_d     = urng_data[47];
                    dataa_d    = urng_data[28:14];
                    segment_d  = {count_lz(urng_data[46:32]), urng_data[31:29]};
                    wait_cnt_d = 8'd0;
                    state_d    = S_SETTLE;
                end else if (!enable) begin
                    state_d = S_IDLE;
                end
            end
            S_SETTLE: begin
                // dp_done may still reflect the previous operands here.
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (dp_done) begin
                    result_d = dp_result;
                    state_d  = S_PUSH;
                end else if (wait_cnt_q == 8'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_PUSH: begin
                mem_d[wr_ptr_q[AW-1:0]] = push_sample;
                wr_ptr_d     = wr_ptr_q + 1'b1;
                sample_cnt_d = sample_cnt_q + 32'd1;
                // Space remains after this push unless it fills the last slot
                // without a simultaneous pop.
                if (enable && (pop || (fifo_count != (AW + 1)'(FIFO_DEPTH - 1)))) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            wait_cnt_q   <= 8'd0;
            dataa_q      <= 15'd0;
            segment_q    <= 7'd0;
            sign_q       <= 1'b0;
            result_q     <= 16'd0;
            timeout_q    <= 1'b0;
            sample_cnt_q <= 32'd0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 16'd0;
            end
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            dataa_q      <= dataa_d;
            segment_q    <= segment_d;
            sign_q       <= sign_d;
            result_q     <= result_d;
            timeout_q    <= timeout_d;
            sample_cnt_q <= sample_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_gng_ctrl.sv
// tb_gng_ctrl - directed self-checking bench for gng_ctrl.
// The datapath is stubbed by the bench: dp_result is either a driven constant
// or, in loopback mode, the zero-extended dp_dataa.
module tb_gng_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [47:0] urng_data;
    logic        urng_valid;
    logic        urng_ready;
    logic [14:0] dp_dataa;
    logic [6:0]  dp_segment;
    logic [15:0] dp_result;
    logic [15:0] dp_result_r;
    logic        loopback;
    logic        dp_done;
    logic [15:0] noise_data;
    logic        noise_valid;
    logic        noise_ready;
    logic        busy;
    logic        timeout_err;
    logic [31:0] sample_cnt;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_cnt = 32'd0;

    assign dp_result = loopback ? {1'b0, dp_dataa} : dp_result_r;

    always #5 clk = ~clk;

    gng_ctrl #(.TIMEOUT(64), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .urng_data  (urng_data),
        .urng_valid (urng_valid),
        .urng_ready (urng_ready),
        .dp_dataa   (dp_dataa),
        .dp_segment (dp_segment),
        .dp_result  (dp_result),
        .dp_done    (dp_done),
        .noise_data (noise_data),
        .noise_valid(noise_valid),
        .noise_ready(noise_ready),
        .busy       (busy),
        .timeout_err(timeout_err),
        .sample_cnt (sample_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait until the controller offers urng_ready.
    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (urng_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Runs one complete sample and leaves the FSM idle with the sample pushed.
    task automatic do_sample(input logic [47:0] w, input logic [15:0] res, output bit ok);
        urng_data   = w;
        urng_valid  = 1'b1;
        dp_result_r = res;
        dp_done     = 1'b0;
        enable      = 1'b1;
        wait_ready(ok);
        if (!ok) return;
        tick();
        urng_valid = 1'b0;
        urng_data  = 48'hFFFF_FFFF_FFFF;
        dp_done    = 1'b1;
        enable     = 1'b0;
        tick();
        tick();
        tick();
        dp_done = 1'b0;
    endtask

    task automatic pop_one();
        noise_ready = 1'b1;
        tick();
        noise_ready = 1'b0;
    endtask

    task automatic test_reset();
        bit ok;
        rst = 1'b0;
        repeat (2) tick();
        checks++;
        if ({urng_ready, noise_valid, busy, timeout_err, sample_cnt, dp_dataa, dp_segment, noise_data} !== 74'd0) begin
            errors++;
            $display("FAIL reset_initial: outputs=%h required 0",
                     {urng_ready, noise_valid, busy, timeout_err, sample_cnt, dp_dataa, dp_segment, noise_data});
        end
        rst = 1'b1;
        tick();
        do_sample({1'b0, 15'h4000, 3'b010, 15'h0123, 14'h0}, 16'h0055, ok);
        // Second sample left hanging in WAIT, then reset mid-flight.
        urng_data  = {1'b1, 15'h0100, 3'b101, 15'h5A5A, 14'h0};
        urng_valid = 1'b1;
        dp_done    = 1'b0;
        enable     = 1'b1;
        wait_ready(ok);
        tick();
        urng_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (!ok || busy !== 1'b1 || noise_valid !== 1'b1 || sample_cnt !== 32'd1) begin
            errors++;
            $display("FAIL reset_precondition: ok=%0d busy=%b valid=%b cnt=%0d required 1 1 1 1",
                     ok, busy, noise_valid, sample_cnt);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({urng_ready, noise_valid, busy, timeout_err, sample_cnt, dp_dataa, dp_segment, noise_data} !== 74'd0) begin
            errors++;
            $display("FAIL reset_async_mid_wait: outputs=%h required 0",
                     {urng_ready, noise_valid, busy, timeout_err, sample_cnt, dp_dataa, dp_segment, noise_data});
        end
        enable = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (5) tick();
        checks++;
        if (busy !== 1'b0 || urng_ready !== 1'b0 || noise_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_stays_idle: busy=%b ready=%b valid=%b required 0 0 0",
                     busy, urng_ready, noise_valid);
        end
        exp_cnt = 32'd0;
    endtask

    task automatic test_field_split();
        bit ok;
        urng_data   = {1'b0, 15'b000100000000000, 3'b001, 15'b100010001001001, 14'h2AAA};
        urng_valid  = 1'b1;
        dp_result_r = 16'h1234;
        dp_done     = 1'b0;
        enable      = 1'b1;
        wait_ready(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL field_wait_ready: urng_ready never rose within 20 cycles");
        end
        tick();
        urng_valid = 1'b0;
        urng_data  = 48'hFFFF_FFFF_FFFF;
        dp_done    = 1'b1;
        checks++;
        if (dp_segment !== 7'd25 || dp_dataa !== 15'h4449 || urng_ready !== 1'b0) begin
            errors++;
            $display("FAIL field_split: seg=%0d dataa=%h ready=%b required 25 4449 0",
                     dp_segment, dp_dataa, urng_ready);
        end
        tick();
        enable = 1'b0;
        checks++;
        if (noise_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_settle_ignores_done: noise_valid=%b required 0", noise_valid);
        end
        tick();
        checks++;
        if (noise_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL latency_push_cycle: noise_valid=%b busy=%b required 0 1", noise_valid, busy);
        end
        tick();
        dp_done = 1'b0;
        exp_cnt = exp_cnt + 32'd1;
        checks++;
        if (noise_valid !== 1'b1 || noise_data !== 16'h1234 || sample_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL latency_sample: valid=%b data=%h cnt=%0d required 1 1234 %0d",
                     noise_valid, noise_data, sample_cnt, exp_cnt);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || dp_segment !== 7'd25 || dp_dataa !== 15'h4449) begin
            errors++;
            $display("FAIL operands_held_idle: busy=%b seg=%0d dataa=%h required 0 25 4449",
                     busy, dp_segment, dp_dataa);
        end
        pop_one();
        checks++;
        if (noise_valid !== 1'b0) begin
            errors++;
            $display("FAIL pop_empties: noise_valid=%b required 0", noise_valid);
        end
    endtask

    task automatic test_sign_sat();
        logic [47:0] words [3];
        logic [15:0] res   [3];
        logic [15:0] expv  [3];
        bit ok;
        words[0] = {1'b1, 15'h4000, 3'b000, 15'h0001, 14'h0}; res[0] = 16'h1234; expv[0] = 16'hEDCC;
        words[1] = {1'b1, 15'h2000, 3'b011, 15'h0002, 14'h0}; res[1] = 16'h9000; expv[1] = 16'h8001;
        words[2] = {1'b0, 15'h0001, 3'b100, 15'h0003, 14'h0}; res[2] = 16'hFFFF; expv[2] = 16'h7FFF;
        for (int k = 0; k < 3; k++) begin
            do_sample(words[k], res[k], ok);
            exp_cnt = exp_cnt + 32'd1;
            checks++;
            if (!ok || noise_valid !== 1'b1 || noise_data !== expv[k] || sample_cnt !== exp_cnt) begin
                errors++;
                $display("FAIL sign_sat_%0d: ok=%0d valid=%b data=%h cnt=%0d required 1 1 %h %0d",
                         k, ok, noise_valid, noise_data, sample_cnt, expv[k], exp_cnt);
            end
            pop_one();
        end
    endtask

    task automatic test_zero_clamp();
        bit ok;
        do_sample({1'b0, 15'h0000, 3'b111, 15'h7FFF, 14'h1FFF}, 16'h0100, ok);
        exp_cnt = exp_cnt + 32'd1;
        checks++;
        if (!ok || dp_segment !== 7'd127 || dp_dataa !== 15'h7FFF || noise_data !== 16'h0100) begin
            errors++;
            $display("FAIL zero_clamp: ok=%0d seg=%0d dataa=%h data=%h required 1 127 7fff 0100",
                     ok, dp_segment, dp_dataa, noise_data);
        end
        pop_one();
    endtask

    task automatic test_backpressure();
        int hs;
        int late_ready;
        hs          = 0;
        late_ready  = 0;
        loopback    = 1'b1;
        dp_done     = 1'b1;
        noise_ready = 1'b0;
        urng_valid  = 1'b1;
        enable      = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (urng_ready) begin
                hs++;
                urng_data = {1'b0, 15'h4000, 3'b000, 15'(hs), 14'h0};
            end
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            if (urng_ready) late_ready++;
            tick();
        end
        exp_cnt = exp_cnt + 32'd4;
        checks++;
        if (hs != 4 || late_ready != 0 || sample_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL backpressure_fill: fetches=%0d late_ready=%0d cnt=%0d required 4 0 %0d",
                     hs, late_ready, sample_cnt, exp_cnt);
        end
        checks++;
        if (noise_valid !== 1'b1 || noise_data !== 16'd1) begin
            errors++;
            $display("FAIL backpressure_head: valid=%b data=%h required 1 0001", noise_valid, noise_data);
        end
        pop_one();
        for (int i = 0; i < 30; i++) begin
            if (urng_ready) begin
                hs++;
                urng_data = {1'b0, 15'h4000, 3'b000, 15'(hs), 14'h0};
            end
            tick();
        end
        exp_cnt = exp_cnt + 32'd1;
        checks++;
        if (hs != 5 || sample_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL backpressure_one_refetch: fetches=%0d cnt=%0d required 5 %0d",
                     hs, sample_cnt, exp_cnt);
        end
        enable     = 1'b0;
        urng_valid = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            checks++;
            if (noise_valid !== 1'b1 || noise_data !== 16'(k)) begin
                errors++;
                $display("FAIL fifo_order_%0d: valid=%b data=%h required 1 %h",
                         k, noise_valid, noise_data, 16'(k));
            end
            pop_one();
        end
        checks++;
        if (noise_valid !== 1'b0) begin
            errors++;
            $display("FAIL fifo_drained: noise_valid=%b required 0", noise_valid);
        end
        dp_done  = 1'b0;
        loopback = 1'b0;
    endtask

    task automatic test_timeout();
        bit ok;
        urng_data  = {1'b0, 15'h4000, 3'b000, 15'h0042, 14'h0};
        urng_valid = 1'b1;
        dp_done    = 1'b0;
        enable     = 1'b1;
        wait_ready(ok);
        tick();
        urng_valid = 1'b0;
        tick();
        repeat (63) tick();
        checks++;
        if (!ok || timeout_err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early: ok=%0d timeout_err=%b busy=%b required 1 0 1",
                     ok, timeout_err, busy);
        end
        tick();
        enable = 1'b0;
        checks++;
        if (timeout_err !== 1'b1 || busy !== 1'b0 || noise_valid !== 1'b0 || sample_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL timeout_flag: err=%b busy=%b valid=%b cnt=%0d required 1 0 0 %0d",
                     timeout_err, busy, noise_valid, sample_cnt, exp_cnt);
        end
        do_sample({1'b1, 15'h0800, 3'b001, 15'h0042, 14'h0}, 16'h0042, ok);
        exp_cnt = exp_cnt + 32'd1;
        checks++;
        if (!ok || noise_data !== 16'hFFBE || sample_cnt !== exp_cnt || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_recover: ok=%0d data=%h cnt=%0d err=%b required 1 ffbe %0d 1",
                     ok, noise_data, sample_cnt, timeout_err, exp_cnt);
        end
        pop_one();
    endtask

    initial begin
        rst         = 1'b0;
        enable      = 1'b0;
        urng_data   = 48'd0;
        urng_valid  = 1'b0;
        dp_result_r = 16'd0;
        loopback    = 1'b0;
        dp_done     = 1'b0;
        noise_ready = 1'b0;
        test_reset();
        test_field_split();
        test_sign_sat();
        test_zero_clamp();
        test_backpressure();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
